// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and the status-flag decode used by fifo_ctrl.
package fifo_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  function automatic fifo_flags_t calc_flags(input int cnt, input int cap,
                                             input int af_level, input int ae_level);
    fifo_flags_t f;
    f.full         = (cnt == cap);
    f.empty        = (cnt == 0);
    f.almost_full  = (cnt >= af_level);
    f.almost_empty = (cnt <= ae_level);
    return f;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register; the MSB acts as the wrap bit above the RAM address bits.
module fifo_ptr #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy, status flags and the
// active-low enable interface to the external storage RAM.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int AF_LEVEL = 2**DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [DEPTH:0]   count,
  output logic             overflow,
  output logic             underflow,
  output logic             ram_wr_ena,
  output logic             ram_valid_write,
  output logic [DEPTH-1:0] ram_wr_adb,
  output logic [WIDTH-1:0] ram_wr_data,
  output logic             ram_rd_ena,
  output logic [DEPTH-1:0] ram_rd_adb,
  input  logic [WIDTH-1:0] ram_rd_data
);

  localparam int CAP = 2**DEPTH;

  logic [DEPTH:0]   count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             push_acc, pop_acc;
  logic [DEPTH:0]   wr_ptr, rd_ptr;
  fifo_flags_t      flags;

  // Flags come only from the registered count, so push/pop never reach them.
  assign flags = calc_flags(int'(count_q), CAP, AF_LEVEL, AE_LEVEL);

  // Holding rst_n low also blocks accepts, so nothing is written during reset.
  always_comb begin
    pop_acc  = rst_n & pop & ~flags.empty;
    push_acc = rst_n & push & (~flags.full | pop_acc);
  end

  fifo_ptr #(.W(DEPTH+1)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.W(DEPTH+1)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop_acc),
    .ptr   (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + (DEPTH+1)'(1);
      2'b01:   count_d = count_q - (DEPTH+1)'(1);
      default: count_d = count_q;
    endcase
    // RAM data is only driven while the read enable is low, i.e. on pop_acc.
    dout_d       = pop_acc ? ram_rd_data : dout_q;
    dout_valid_d = pop_acc;
    overflow_d   = rst_n & push & ~push_acc;
    underflow_d  = rst_n & pop & ~pop_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign ram_wr_ena      = ~push_acc;
  assign ram_valid_write = push_acc;
  assign ram_wr_adb      = wr_ptr[DEPTH-1:0];
  assign ram_wr_data     = din;
  assign ram_rd_ena      = ~pop_acc;
  assign ram_rd_adb      = rd_ptr[DEPTH-1:0];

  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;
  assign count        = count_q;
  assign full         = flags.full;
  assign empty        = flags.empty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with a behavioural RAM and a queue-based FIFO reference.
module tb_fifo_ctrl;

  localparam int DEPTH = 3;
  localparam int WIDTH = 4;
  localparam int CAP   = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             push = 1'b0;
  logic             pop  = 1'b0;
  logic [WIDTH-1:0] din  = '0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid, full, empty, almost_full, almost_empty;
  logic [DEPTH:0]   count;
  logic             overflow, underflow;
  logic             ram_wr_ena, ram_valid_write, ram_rd_ena;
  logic [DEPTH-1:0] ram_wr_adb, ram_rd_adb;
  logic [WIDTH-1:0] ram_wr_data;
  wire  [WIDTH-1:0] ram_rd_data;

  fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .push            (push),
    .din             (din),
    .pop             (pop),
    .dout            (dout),
    .dout_valid      (dout_valid),
    .full            (full),
    .empty           (empty),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .count           (count),
    .overflow        (overflow),
    .underflow       (underflow),
    .ram_wr_ena      (ram_wr_ena),
    .ram_valid_write (ram_valid_write),
    .ram_wr_adb      (ram_wr_adb),
    .ram_wr_data     (ram_wr_data),
    .ram_rd_ena      (ram_rd_ena),
    .ram_rd_adb      (ram_rd_adb),
    .ram_rd_data     (ram_rd_data)
  );

  // Storage RAM: write on posedge when enabled, combinational read, Z when idle.
  logic [WIDTH-1:0] mem [CAP];
  int wr_events = 0;
  always @(posedge clk) begin
    if (!ram_wr_ena && ram_valid_write) begin
      mem[ram_wr_adb] <= ram_wr_data;
      wr_events <= wr_events + 1;
    end
  end
  assign ram_rd_data = ram_rd_ena ? {WIDTH{1'bz}} : mem[ram_rd_adb];

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_dout = '0;
  logic exp_dv = 1'b0, exp_ovf = 1'b0, exp_udf = 1'b0;
  int n_push = 0, n_pop = 0;
  int total = 0, bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status();
    int sz;
    sz = exp_q.size();
    check_val("count",        32'(count),        32'(sz));
    check_val("full",         32'(full),         32'(sz == CAP));
    check_val("empty",        32'(empty),        32'(sz == 0));
    check_val("almost_full",  32'(almost_full),  32'(sz >= AF));
    check_val("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    check_val("dout_valid",   32'(dout_valid),   32'(exp_dv));
    check_val("dout",         32'(dout),         32'(exp_dout));
    check_val("overflow",     32'(overflow),     32'(exp_ovf));
    check_val("underflow",    32'(underflow),    32'(exp_udf));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic r);
    logic pa, wa;
    @(negedge clk);
    push = p; din = d; pop = r;
    #1;
    pa = r && (exp_q.size() > 0);
    wa = p && ((exp_q.size() < CAP) || pa);
    check_val("ram_wr_ena",      32'(ram_wr_ena),      32'(!wa));
    check_val("ram_valid_write", 32'(ram_valid_write), 32'(wa));
    check_val("ram_rd_ena",      32'(ram_rd_ena),      32'(!pa));
    check_val("ram_wr_adb",      32'(ram_wr_adb),      32'(n_push % CAP));
    check_val("ram_rd_adb",      32'(ram_rd_adb),      32'(n_pop % CAP));
    check_val("ram_wr_data",     32'(ram_wr_data),     32'(d));
    @(posedge clk);
    #1;
    exp_dv  = pa;
    exp_ovf = p && !wa;
    exp_udf = r && !pa;
    if (pa) begin
      exp_dout = exp_q.pop_front();
      n_pop++;
    end
    if (wa) begin
      exp_q.push_back(d);
      n_push++;
    end
    check_status();
  endtask

  // Assert reset mid-cycle with an optional push on the bus; it must be lost.
  task automatic reset_with(input logic p, input logic [WIDTH-1:0] d);
    int ev;
    @(negedge clk);
    push = p; din = d; pop = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_push = 0; n_pop = 0;
    exp_dout = '0; exp_dv = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
    check_status();
    check_val("rst_wr_ena",  32'(ram_wr_ena),      32'(1));
    check_val("rst_valid",   32'(ram_valid_write), 32'(0));
    check_val("rst_rd_ena",  32'(ram_rd_ena),      32'(1));
    check_val("rst_wr_adb",  32'(ram_wr_adb),      32'(0));
    check_val("rst_rd_adb",  32'(ram_rd_adb),      32'(0));
    ev = wr_events;
    @(posedge clk);
    #1;
    check_val("rst_no_write", 32'(wr_events), 32'(ev));
    check_status();
    @(negedge clk);
    rst_n = 1'b1;
    push = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_with(1'b0, '0);

    for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 1'b0);
    step(1'b1, 4'h9, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    step(1'b1, 4'hA, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'h5, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0);

    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 3), 1'b0);
    reset_with(1'b1, 4'hF);
    step(1'b0, 4'h0, 1'b1);

    for (int ph = 0; ph < 6; ph++) begin
      int pw, rw;
      pw = $urandom_range(20, 90);
      rw = $urandom_range(20, 90);
      for (int c = 0; c < 80; c++) begin
        if ($urandom_range(0, 199) == 0) begin
          reset_with(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end else begin
          step(1'($urandom_range(0, 99) < pw), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 99) < rw));
        end
      end
    end

    while (exp_q.size() > 0) step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
